// File: rtl/pong_match_ctrl.sv
// Pong match sequencer: frame tick, idle/serve/play/over control, BCD score and lives.
// Define PONG_SPEEDUP_EN to drop the ball-step period to one frame once the score reaches 10.
module pong_match_ctrl #(
   parameter int unsigned FRAME_H      = 800,
   parameter int unsigned FRAME_V      = 480,
   parameter int unsigned SERVE_FRAMES = 60,
   parameter int unsigned STEP_FRAMES  = 2,
   parameter int unsigned LIVES        = 3
) (
   input  logic        VGA_CLOCK,
   input  logic        RESET,
   input  logic [10:0] PIXEL_H,
   input  logic [10:0] PIXEL_V,
   input  logic        START,
   input  logic        PADDLE_HIT,
   input  logic        BALL_MISSED,
   output logic        FRAME_TICK,
   output logic        SERVE,
   output logic        BALL_STEP,
   output logic        BALL_RUN,
   output logic        GAME_OVER,
   output logic [7:0]  SCORE,
   output logic [1:0]  LIVES_LEFT,
   output logic [1:0]  STATE
);

   typedef enum logic [1:0] {
      StIdle      = 2'd0,
      StServeWait = 2'd1,
      StPlay      = 2'd2,
      StOver      = 2'd3
   } state_e;

   localparam logic [10:0] FrameH     = 11'(FRAME_H);
   localparam logic [10:0] FrameV     = 11'(FRAME_V);
   localparam logic [7:0]  ServeLast  = 8'(SERVE_FRAMES - 1);
   localparam logic [3:0]  StepLast   = 4'(STEP_FRAMES - 1);
   localparam logic [1:0]  LivesInit  = 2'(LIVES);

   state_e      state_q, state_d;
   logic        tick_q, frame_tick_q;
   logic        start_q, start_prev_q;
   logic [7:0]  serve_cnt_q, serve_cnt_d;
   logic [3:0]  step_cnt_q, step_cnt_d;
   logic [7:0]  score_q, score_d;
   logic [1:0]  lives_q, lives_d;
   logic        serve_q, serve_d;
   logic        step_q, step_d;
   logic        run_q, run_d;
   logic        over_q, over_d;
   logic        start_edge;
   logic [3:0]  step_last;

`ifdef PONG_SPEEDUP_EN
   logic        fast_q, fast_d;

   // Period is only re-evaluated when the step counter restarts.
   assign step_last = fast_q ? 4'd0 : StepLast;
`else
   assign step_last = StepLast;
`endif

   assign start_edge = start_q & ~start_prev_q;

   always_comb begin
      state_d     = state_q;
      serve_cnt_d = serve_cnt_q;
      step_cnt_d  = step_cnt_q;
      score_d     = score_q;
      lives_d     = lives_q;
      serve_d     = 1'b0;
      step_d      = 1'b0;
`ifdef PONG_SPEEDUP_EN
      fast_d      = fast_q;
`endif
      unique case (state_q)
         StIdle, StOver: begin
            if (start_edge) begin
               score_d     = 8'h00;
               lives_d     = LivesInit;
               serve_cnt_d = 8'd0;
               state_d     = StServeWait;
            end
         end
         StServeWait: begin
            if (frame_tick_q) begin
               serve_cnt_d = serve_cnt_q + 8'd1;
               if (serve_cnt_q == ServeLast) begin
                  state_d    = StPlay;
                  serve_d    = 1'b1;
                  step_cnt_d = 4'd0;
`ifdef PONG_SPEEDUP_EN
                  fast_d     = (score_q[7:4] != 4'd0);
`endif
               end
            end
         end
         StPlay: begin
            // A miss wins over a simultaneous hit or step.
            if (BALL_MISSED) begin
               if (lives_q > 2'd1) begin
                  lives_d     = lives_q - 2'd1;
                  serve_cnt_d = 8'd0;
                  state_d     = StServeWait;
               end else begin
                  lives_d = 2'd0;
                  state_d = StOver;
               end
            end else begin
               if (PADDLE_HIT && score_q != 8'h99) begin
                  if (score_q[3:0] == 4'd9) begin
                     score_d = {score_q[7:4] + 4'd1, 4'd0};
                  end else begin
                     score_d = {score_q[7:4], score_q[3:0] + 4'd1};
                  end
               end
               if (frame_tick_q) begin
                  if (step_cnt_q == step_last) begin
                     step_d     = 1'b1;
                     step_cnt_d = 4'd0;
`ifdef PONG_SPEEDUP_EN
                     fast_d     = (score_q[7:4] != 4'd0);
`endif
                  end else begin
                     step_cnt_d = step_cnt_q + 4'd1;
                  end
               end
            end
         end
      endcase
      run_d  = (state_d == StPlay);
      over_d = (state_d == StOver);
   end

   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         state_q      <= StIdle;
         tick_q       <= 1'b0;
         frame_tick_q <= 1'b0;
         start_q      <= 1'b0;
         start_prev_q <= 1'b0;
         serve_cnt_q  <= 8'd0;
         step_cnt_q   <= 4'd0;
         score_q      <= 8'h00;
         lives_q      <= LivesInit;
         serve_q      <= 1'b0;
         step_q       <= 1'b0;
         run_q        <= 1'b0;
         over_q       <= 1'b0;
      end else begin
         state_q      <= state_d;
         tick_q       <= (PIXEL_H == FrameH) && (PIXEL_V == FrameV);
         frame_tick_q <= tick_q;
         start_q      <= START;
         start_prev_q <= start_q;
         serve_cnt_q  <= serve_cnt_d;
         step_cnt_q   <= step_cnt_d;
         score_q      <= score_d;
         lives_q      <= lives_d;
         serve_q      <= serve_d;
         step_q       <= step_d;
         run_q        <= run_d;
         over_q       <= over_d;
      end
   end

`ifdef PONG_SPEEDUP_EN
   always_ff @(posedge VGA_CLOCK or posedge RESET) begin
      if (RESET) begin
         fast_q <= 1'b0;
      end else begin
         fast_q <= fast_d;
      end
   end
`endif

   assign FRAME_TICK = frame_tick_q;
   assign SERVE      = serve_q;
   assign BALL_STEP  = step_q;
   assign BALL_RUN   = run_q;
   assign GAME_OVER  = over_q;
   assign SCORE      = score_q;
   assign LIVES_LEFT = lives_q;
   assign STATE      = state_q;

endmodule

// File: tb/tb_pong_match_ctrl.sv
// Self-checking bench for pong_match_ctrl: directed vector table, hand sequences and
// randomized stimulus against a match-level reference model.
module tb_pong_match_ctrl;

   localparam int FH = 8, FV = 4, SF = 2, SP = 2, LV = 3;

   logic        VGA_CLOCK = 1'b0;
   logic        RESET = 1'b1;
   logic [10:0] PIXEL_H = '0, PIXEL_V = '0;
   logic        START = 1'b0, PADDLE_HIT = 1'b0, BALL_MISSED = 1'b0;
   logic        FRAME_TICK, SERVE, BALL_STEP, BALL_RUN, GAME_OVER;
   logic [7:0]  SCORE;
   logic [1:0]  LIVES_LEFT, STATE;

   pong_match_ctrl #(
      .FRAME_H(FH), .FRAME_V(FV), .SERVE_FRAMES(SF), .STEP_FRAMES(SP), .LIVES(LV)
   ) dut (
      .VGA_CLOCK(VGA_CLOCK), .RESET(RESET), .PIXEL_H(PIXEL_H), .PIXEL_V(PIXEL_V),
      .START(START), .PADDLE_HIT(PADDLE_HIT), .BALL_MISSED(BALL_MISSED),
      .FRAME_TICK(FRAME_TICK), .SERVE(SERVE), .BALL_STEP(BALL_STEP), .BALL_RUN(BALL_RUN),
      .GAME_OVER(GAME_OVER), .SCORE(SCORE), .LIVES_LEFT(LIVES_LEFT), .STATE(STATE)
   );

   always #5 VGA_CLOCK = ~VGA_CLOCK;

   int total = 0, bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         if (bad <= 40) $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: match state and score kept as plain integers.
   int m_state, m_score, m_lives, m_scnt, m_stcnt;
   bit m_serve, m_step, m_ft, m_tk, m_s, m_sp;

   function automatic logic [7:0] bcd(input int v);
      logic [7:0] r;
      r[7:4] = 4'(v / 10);
      r[3:0] = 4'(v % 10);
      return r;
   endfunction

   task automatic model_reset();
      m_state = 0; m_score = 0; m_lives = LV; m_scnt = 0; m_stcnt = 0;
      m_serve = 0; m_step = 0; m_ft = 0; m_tk = 0; m_s = 0; m_sp = 0;
   endtask

   task automatic model_step();
      bit edge_s;
      if (RESET) begin
         model_reset();
      end else begin
         edge_s = m_s && !m_sp;
         m_serve = 0;
         m_step  = 0;
         case (m_state)
            0, 3: if (edge_s) begin
               m_score = 0; m_lives = LV; m_scnt = 0; m_state = 1;
            end
            1: if (m_ft) begin
               if (m_scnt == SF - 1) begin
                  m_state = 2; m_serve = 1; m_stcnt = 0;
               end else m_scnt++;
            end
            default: begin
               if (BALL_MISSED) begin
                  if (m_lives > 1) begin
                     m_lives--; m_scnt = 0; m_state = 1;
                  end else begin
                     m_lives = 0; m_state = 3;
                  end
               end else begin
                  if (PADDLE_HIT && m_score < 99) m_score++;
                  if (m_ft) begin
                     if (m_stcnt == SP - 1) begin
                        m_step = 1; m_stcnt = 0;
                     end else m_stcnt++;
                  end
               end
            end
         endcase
         m_sp = m_s;
         m_s  = START;
         m_ft = m_tk;
         m_tk = (PIXEL_H == 11'(FH)) && (PIXEL_V == 11'(FV));
      end
   endtask

   task automatic check_model();
      chk("model STATE", 32'(STATE), 32'(m_state));
      chk("model SCORE", 32'(SCORE), 32'(bcd(m_score)));
      chk("model LIVES_LEFT", 32'(LIVES_LEFT), 32'(m_lives));
      chk("model FRAME_TICK", 32'(FRAME_TICK), 32'(m_ft));
      chk("model SERVE", 32'(SERVE), 32'(m_serve));
      chk("model BALL_STEP", 32'(BALL_STEP), 32'(m_step));
      chk("model BALL_RUN", 32'(BALL_RUN), 32'(m_state == 2));
      chk("model GAME_OVER", 32'(GAME_OVER), 32'(m_state == 3));
   endtask

   int  n_serve, n_step;
   logic last_ft = 1'b0;

   // One clock: drive inputs, step model at the edge, sample 1 time unit later.
   task automatic cyc(input logic r, input logic s, input logic h, input logic m, input logic t);
      RESET = r; START = s; PADDLE_HIT = h; BALL_MISSED = m;
      PIXEL_H = t ? 11'(FH) : 11'd0;
      PIXEL_V = t ? 11'(FV) : 11'd0;
      @(posedge VGA_CLOCK);
      model_step();
      #1;
      check_model();
      if (SERVE === 1'b1) n_serve++;
      if (BALL_STEP === 1'b1) n_step++;
      if (SERVE === 1'b1 || BALL_STEP === 1'b1) chk("strobe follows FRAME_TICK", 32'(last_ft), 1);
      last_ft = FRAME_TICK;
   endtask

   task automatic frame();
      cyc(0, 0, 0, 0, 1);
      repeat (3) cyc(0, 0, 0, 0, 0);
   endtask

   task automatic wait_state(input logic [1:0] target, input string name);
      int k = 0;
      while (STATE !== target && k < 20) begin
         frame();
         k++;
      end
      chk(name, 32'(STATE), 32'(target));
   endtask

   task automatic new_match();
      cyc(0, 1, 0, 0, 0);
      cyc(0, 1, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
   endtask

   typedef struct {
      logic s, h, m, t;
      logic [1:0] st;
      logic sv, stp, ft;
      logic [7:0] sc;
      logic [1:0] lv;
   } vec_t;

   vec_t tbl[17];

   initial begin
      tbl[0]  = '{1, 0, 0, 0, 2'd0, 0, 0, 0, 8'h00, 2'd3};
      tbl[1]  = '{1, 0, 0, 0, 2'd1, 0, 0, 0, 8'h00, 2'd3};
      tbl[2]  = '{0, 0, 0, 1, 2'd1, 0, 0, 0, 8'h00, 2'd3};
      tbl[3]  = '{0, 0, 0, 0, 2'd1, 0, 0, 1, 8'h00, 2'd3};
      tbl[4]  = '{0, 0, 0, 0, 2'd1, 0, 0, 0, 8'h00, 2'd3};
      tbl[5]  = '{0, 0, 0, 1, 2'd1, 0, 0, 0, 8'h00, 2'd3};
      tbl[6]  = '{0, 0, 0, 0, 2'd1, 0, 0, 1, 8'h00, 2'd3};
      tbl[7]  = '{0, 0, 0, 0, 2'd2, 1, 0, 0, 8'h00, 2'd3};
      tbl[8]  = '{0, 1, 0, 0, 2'd2, 0, 0, 0, 8'h01, 2'd3};
      tbl[9]  = '{0, 0, 0, 1, 2'd2, 0, 0, 0, 8'h01, 2'd3};
      tbl[10] = '{0, 0, 0, 0, 2'd2, 0, 0, 1, 8'h01, 2'd3};
      tbl[11] = '{0, 0, 0, 0, 2'd2, 0, 0, 0, 8'h01, 2'd3};
      tbl[12] = '{0, 0, 0, 1, 2'd2, 0, 0, 0, 8'h01, 2'd3};
      tbl[13] = '{0, 0, 0, 0, 2'd2, 0, 0, 1, 8'h01, 2'd3};
      tbl[14] = '{0, 0, 0, 0, 2'd2, 0, 1, 0, 8'h01, 2'd3};
      tbl[15] = '{0, 1, 1, 0, 2'd1, 0, 0, 0, 8'h01, 2'd2};
      tbl[16] = '{0, 0, 0, 0, 2'd1, 0, 0, 0, 8'h01, 2'd2};

      model_reset();
      cyc(1, 0, 0, 0, 0);
      cyc(1, 0, 0, 0, 0);
      chk("reset STATE", 32'(STATE), 0);
      chk("reset LIVES_LEFT", 32'(LIVES_LEFT), 3);
      chk("reset SCORE", 32'(SCORE), 0);
      cyc(0, 0, 0, 0, 0);

      // Directed vector table.
      for (int i = 0; i < 17; i++) begin
         cyc(0, tbl[i].s, tbl[i].h, tbl[i].m, tbl[i].t);
         chk($sformatf("vec%0d STATE", i), 32'(STATE), 32'(tbl[i].st));
         chk($sformatf("vec%0d SERVE", i), 32'(SERVE), 32'(tbl[i].sv));
         chk($sformatf("vec%0d BALL_STEP", i), 32'(BALL_STEP), 32'(tbl[i].stp));
         chk($sformatf("vec%0d FRAME_TICK", i), 32'(FRAME_TICK), 32'(tbl[i].ft));
         chk($sformatf("vec%0d SCORE", i), 32'(SCORE), 32'(tbl[i].sc));
         chk($sformatf("vec%0d LIVES_LEFT", i), 32'(LIVES_LEFT), 32'(tbl[i].lv));
      end

      // Fresh match: serve, step rate, BCD score, saturation.
      cyc(1, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0);
      n_serve = 0;
      new_match();
      chk("start STATE", 32'(STATE), 1);
      wait_state(2'd2, "reach PLAY");
      chk("serve count", 32'(n_serve), 1);
      n_step = 0;
      repeat (6) frame();
      chk("steps in 6 frames", 32'(n_step), 3);
      repeat (12) cyc(0, 0, 1, 0, 0);
      chk("score after 12 hits", 32'(SCORE), 32'h12);
      repeat (86) cyc(0, 0, 1, 0, 0);
      chk("score 98", 32'(SCORE), 32'h98);
      repeat (3) cyc(0, 0, 1, 0, 0);
      chk("score saturates", 32'(SCORE), 32'h99);

      // Three misses end the match.
      for (int i = 0; i < 3; i++) begin
         if (i > 0) wait_state(2'd2, "reach PLAY before miss");
         cyc(0, 0, 0, 1, 0);
         chk("lives after miss", 32'(LIVES_LEFT), 32'(2 - i));
         chk("state after miss", 32'(STATE), (i < 2) ? 32'd1 : 32'd3);
      end
      chk("GAME_OVER", 32'(GAME_OVER), 1);
      chk("score held at over", 32'(SCORE), 32'h99);
      repeat (3) frame();
      chk("over holds", 32'(STATE), 3);

      // New match from OVER; hit and miss together.
      new_match();
      chk("restart score", 32'(SCORE), 0);
      chk("restart lives", 32'(LIVES_LEFT), 3);
      wait_state(2'd2, "reach PLAY again");
      repeat (5) cyc(0, 0, 1, 0, 0);
      cyc(0, 0, 1, 1, 0);
      chk("hit+miss score", 32'(SCORE), 32'h05);
      chk("hit+miss lives", 32'(LIVES_LEFT), 2);
      chk("hit+miss state", 32'(STATE), 1);

      // Reset mid-PLAY coincident with a frame tick.
      wait_state(2'd2, "reach PLAY for reset");
      begin
         int k = 0;
         cyc(0, 0, 0, 0, 1);
         while (FRAME_TICK !== 1'b1 && k < 8) begin
            cyc(0, 0, 0, 0, 0);
            k++;
         end
         chk("tick before reset", 32'(FRAME_TICK), 1);
      end
      RESET = 1'b1;
      #1;
      chk("async reset STATE", 32'(STATE), 0);
      chk("async reset FRAME_TICK", 32'(FRAME_TICK), 0);
      chk("async reset SCORE", 32'(SCORE), 0);
      chk("async reset LIVES", 32'(LIVES_LEFT), 3);
      chk("async reset BALL_RUN", 32'(BALL_RUN), 0);
      cyc(1, 0, 0, 0, 0);
      n_serve = 0;
      n_step = 0;
      repeat (10) frame();
      chk("no serve after reset", 32'(n_serve), 0);
      chk("no step after reset", 32'(n_step), 0);
      chk("idle after reset", 32'(STATE), 0);

      // Randomized play against the model.
      begin
         logic s = 1'b0;
         for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 5) == 0) s = ~s;
            cyc(($urandom_range(0, 599) == 0), s, ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 24) == 0), ($urandom_range(0, 3) == 0));
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/pong_match_ctrl.md
# pong_match_ctrl

Match sequencer for the pong game engine. It derives a once-per-frame tick from the VGA scan position and sequences each match through idle, serve, play and game over. In play it issues single-cycle ball-step strobes that pace the ball datapath, and on a miss it issues a single-cycle serve strobe so the engine re-centres the ball. It also keeps the BCD hit score and the lives counter shown on screen.

## Interface
Parameters:
- FRAME_H, 800: horizontal scan position that defines the frame tick.
- FRAME_V, 480: vertical scan position that defines the frame tick.
- SERVE_FRAMES, 60: frames held in the serve pause, range 1..255.
- STEP_FRAMES, 2: frames per ball step, range 1..15.
- LIVES, 3: lives at match start, range 1..3.

Ports:
- VGA_CLOCK  in  1  pixel clock; every register is clocked on its rising edge.
- RESET  in  1  asynchronous, active-high.
- PIXEL_H  in  11  current horizontal scan position.
- PIXEL_V  in  11  current vertical scan position.
- START  in  1  debounced start button, level signal.
- PADDLE_HIT  in  1  one-cycle pulse from the engine: ball struck the paddle.
- BALL_MISSED  in  1  one-cycle pulse from the engine: ball passed the paddle.
- FRAME_TICK  out  1  one-cycle pulse per frame.
- SERVE  out  1  one-cycle pulse: load the ball at its serve position.
- BALL_STEP  out  1  one-cycle pulse: advance the ball one pixel.
- BALL_RUN  out  1  high while in PLAY.
- GAME_OVER  out  1  high while in OVER.
- SCORE  out  8  two-digit BCD score, tens digit in [7:4].
- LIVES_LEFT  out  2  remaining lives.
- STATE  out  2  encoding: IDLE=0, SERVE_WAIT=1, PLAY=2, OVER=3.

## Operation
- All outputs are registered.
- Reset values:
  - STATE=IDLE.
  - SCORE=8'h00.
  - LIVES_LEFT=LIVES.
  - All pulse outputs, BALL_RUN and GAME_OVER are 0.
  - Internal counters and the START history register are 0.
- Start edge: START is registered each cycle; a start edge is START=1 while the previous sample was 0.
- IDLE:
  - On a start edge: SCORE←0, LIVES_LEFT←LIVES, serve counter←0, go to SERVE_WAIT.
- SERVE_WAIT:
  - Each tick increments the serve counter.
  - On the tick where the counter equals SERVE_FRAMES-1: go to PLAY, pulse SERVE, clear the step counter.
- PLAY:
  - Each tick increments the step counter.
  - When the step counter equals period-1: pulse BALL_STEP and clear the counter.
  - PADDLE_HIT: SCORE increments in BCD, 09→10, and saturates at 99.
  - BALL_MISSED with LIVES_LEFT>1: decrement LIVES_LEFT, clear the serve counter, go to SERVE_WAIT.
  - BALL_MISSED with LIVES_LEFT=1: LIVES_LEFT←0, go to OVER.
- OVER:
  - SCORE is held.
  - On a start edge: behave as the IDLE start edge (new match).
- Simultaneous events:
  - PADDLE_HIT and BALL_MISSED in the same cycle: the miss is processed and the hit is dropped.
  - Tick and BALL_MISSED in the same cycle: no BALL_STEP is issued.
- PADDLE_HIT and BALL_MISSED outside PLAY are ignored.
- The start edge is ignored in SERVE_WAIT and PLAY.
- RESET asserted in any state returns every register to its reset value immediately. No strobe is emitted after release until the normal sequence produces one.

## Timing
- Internal tick:
  - Registered when PIXEL_H==FRAME_H and PIXEL_V==FRAME_V are sampled.
  - FRAME_TICK is the registered copy of the tick, high for exactly one cycle.
  - The scan position holds for one clock, so there is one tick per frame.
- SERVE and BALL_STEP are high for exactly one cycle, in the cycle after the FRAME_TICK cycle that caused them.
- The STATE change is visible in that same cycle.
- The start edge changes STATE 2 cycles after START rises: one cycle for edge detection, one for the state register.
- SCORE and LIVES_LEFT update 1 cycle after the input pulse is sampled.
- Ball-step rate: BALL_STEP recurs every `period` ticks. period=STEP_FRAMES, except as modified under Configuration.

## Configuration
- PONG_SPEEDUP_EN defined: the step period becomes 1 frame once SCORE[7:4]≥1. The change takes effect on the step counter's next wrap, and the counter is cleared on the switch.
- PONG_SPEEDUP_EN undefined: the period is fixed at STEP_FRAMES. The SCORE comparison logic is absent.

## Test plan
Parameters for all scenarios: FRAME_H=8, FRAME_V=4, SERVE_FRAMES=2, STEP_FRAMES=2, LIVES=3.

- Reset then START pulse → STATE goes 0→1 two cycles later. SERVE pulses once, one cycle after the 2nd FRAME_TICK, and STATE=2. LIVES_LEFT=3, SCORE=00.
- In PLAY, run 6 frames → exactly 3 BALL_STEP pulses, each one cycle after every 2nd FRAME_TICK.
- 12 PADDLE_HIT pulses → SCORE=8'h12.
  - Force SCORE to 98 and apply 3 hits → SCORE=99.
  - With the macro defined, after SCORE=10 BALL_STEP follows every FRAME_TICK.
- BALL_MISSED three times, each after reaching PLAY → LIVES_LEFT 2, 1, 0. STATE goes 1, 1, then 3 with GAME_OVER=1. SCORE is unchanged.
- PADDLE_HIT and BALL_MISSED in the same cycle at SCORE=05, LIVES=3 → SCORE=05, LIVES_LEFT=2, STATE=1.
- RESET asserted mid-PLAY coincident with a tick → all outputs at reset values the same cycle. No SERVE or BALL_STEP appears until a new START.
